cl_mem_access_ctrl: RTL and testbench
=====================================

// Module: cl_mem_access_ctrl
// PURPOSE
//  Sequences data-memory accesses for decoded load/store instructions (LW, LBU, SW, SB).
//  Sits between decode/execute and the data memory port.
//  Issues a valid/yumi request and stalls the pipeline until the access completes.
//  Performs byte-lane steering for SB and LBU, and produces the register-file writeback for loads.
// PARAMETERS
//  ADDR_W    32  byte address width
//  DATA_W    32  data width; fixed at 4 byte lanes
//  MAX_WAIT  64  cycles allowed in REQ or RESP before abort (timeout feature only)
// PORTS
//  clk           in   1       single clock; all logic on posedge
//  reset         in   1       synchronous, active-high
//  op_valid_i    in   1       memory op presented (decoded is_mem_op qualified by stage valid)
//  is_load_i     in   1       op is LW/LBU
//  is_store_i    in   1       op is SW/SB
//  is_byte_i     in   1       op is LBU/SB
//  addr_i        in   ADDR_W  effective byte address
//  store_data_i  in   DATA_W  rt value for stores
//  rd_addr_i     in   5       load destination register
//  stall_o       out  1       hold pipeline this cycle
//  dmem_v_o      out  1       memory request valid
//  dmem_we_o     out  1       1 = write
//  dmem_addr_o   out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata_o  out  DATA_W  write data
//  dmem_mask_o   out  4       byte write enables
//  dmem_yumi_i   in   1       memory accepted request this cycle
//  dmem_rv_i     in   1       read response valid
//  dmem_rdata_i  in   DATA_W  read response data
//  wb_v_o        out  1       load writeback valid (one cycle)
//  wb_rd_o       out  5       writeback register
//  wb_data_o     out  DATA_W  writeback data
//  err_misalign_o out 1       one-cycle pulse: word op with addr[1:0]!=0
//  err_timeout_o out  1       one-cycle pulse: access aborted (timeout feature)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; latched op cleared. Reset mid-access abandons the op;
//    a later dmem_rv_i is ignored because rv is sampled only in RESP.
//  - States: IDLE, REQ, RESP, DONE.
//  - IDLE:
//    - op_valid_i & aligned: latch op, addr, data, rd; stall_o=1 combinationally; next REQ.
//    - op_valid_i & misaligned word op: no request; err_misalign_o=1 this cycle; stall_o=0;
//      no writeback; stay IDLE.
//    - op_valid_i with both or neither of is_load_i/is_store_i is treated as no op.
//  - REQ: dmem_v_o=1, stall_o=1. Outputs held stable until dmem_yumi_i.
//    - On yumi: store -> DONE; load -> RESP.
//  - RESP: stall_o=1; dmem_v_o=0. On dmem_rv_i, capture data and go to DONE.
//    rv in the yumi cycle is illegal/ignored.
//  - DONE: stall_o=0 for exactly one cycle; pipeline advances at end of cycle; next IDLE.
//    - op_valid_i in DONE is the completed op and is NOT re-accepted.
//    - Loads: wb_v_o=1, wb_rd_o=latched rd. wb_v_o is suppressed when rd==0.
//  - Latency (zero-wait memory): store = 3 cycles IDLE->REQ->DONE; load = 4 cycles.
//    Each wait cycle adds one.
//  - Store steering:
//    - SW: mask=4'hF, wdata=store_data.
//    - SB: mask=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}.
//  - Load steering:
//    - LW: wb_data=rdata.
//    - LBU: wb_data={24'b0, rdata byte lane addr[1:0]}, little-endian (lane0=[7:0]).
//  - dmem_we_o=is_store (latched); dmem_* outputs are 0 outside REQ.
//  - wb_* outputs are 0 outside DONE.
// CONFIGURATION
//  CL_MEM_TIMEOUT_EN defined:
//    - An 8-bit wait counter, cleared on entering REQ, counts cycles in REQ/RESP.
//    - When the counter reaches MAX_WAIT: go DONE with err_timeout_o=1, wb_v_o=0, dmem_v_o dropped.
//  CL_MEM_TIMEOUT_EN undefined:
//    - No counter; the controller waits indefinitely.
//    - err_timeout_o is tied 0.
// TESTING
//  - LW addr=0x100, yumi immediate, rv 1 cycle later rdata=0xDEADBEEF, rd=5:
//    stall 3 cycles, then wb_v=1, rd=5, data=0xDEADBEEF.
//  - SB addr=0x203, data=0x000000A5:
//    dmem_addr=0x200, mask=4'b1000, wdata=0xA5A5A5A5, we=1; stall 2 cycles; no wb.
//  - LBU addr=0x302, rdata=0x11223344: wb_data=0x00000022.
//    Repeat with rd=0: wb_v stays 0.
//  - SW addr=0x101: err_misalign=1 one cycle, dmem_v never asserted, stall_o=0.
//  - Yumi held low 5 cycles in REQ: dmem_v/addr/wdata/mask stable, stall held.
//    Reset asserted in RESP: next cycle IDLE, outputs 0, later rv ignored.
//  - With CL_MEM_TIMEOUT_EN, MAX_WAIT=4, rv never returns:
//    err_timeout pulse in DONE, wb_v=0, back to IDLE.

Source files
------------

// File: rtl/cl_mem_access_ctrl.sv
// Data-memory access sequencer for LW/LBU/SW/SB: valid/yumi request, pipeline stall, byte-lane steering.
// Define CL_MEM_TIMEOUT_EN to abort accesses that sit in REQ/RESP for MAX_WAIT cycles.
module cl_mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              is_byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic              stall_o,
  output logic              dmem_v_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_mask_o,
  input  logic              dmem_yumi_i,
  input  logic              dmem_rv_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_v_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_misalign_o,
  output logic              err_timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state_reg, state_next;

  logic              load_reg;
  logic              byte_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [4:0]        rd_reg;

  logic              op_kind_ok;
  logic              misaligned;
  logic              accept;
  logic              abort;
  logic              timed_out;
  logic              in_req;
  logic              in_done;
  logic [3:0]        mask_steer;
  logic [DATA_W-1:0] wdata_steer;
  logic [7:0]        rd_lane [4];

  // Exactly one of load/store makes a real memory op; anything else is ignored.
  assign op_kind_ok = is_load_i ^ is_store_i;
  assign misaligned = ~is_byte_i & (addr_i[1:0] != 2'b00);
  assign accept     = (state_reg == IDLE) & op_valid_i & op_kind_ok & ~misaligned;
  assign in_req     = (state_reg == REQ);
  assign in_done    = (state_reg == DONE);

  always_comb begin
    state_next     = state_reg;
    stall_o        = 1'b0;
    err_misalign_o = 1'b0;
    case (state_reg)
      IDLE: begin
        err_misalign_o = op_valid_i & op_kind_ok & misaligned;
        if (accept) begin
          stall_o    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_yumi_i) state_next = load_reg ? RESP : DONE;
        else if (abort)  state_next = DONE;
      end
      RESP: begin
        stall_o = 1'b1;
        if (dmem_rv_i || abort) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      load_reg  <= 1'b0;
      byte_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      rdata_reg <= '0;
      rd_reg    <= 5'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        load_reg <= is_load_i;
        byte_reg <= is_byte_i;
        addr_reg <= addr_i;
        data_reg <= store_data_i;
        rd_reg   <= rd_addr_i;
      end
      // rv is only meaningful in RESP; a response in the yumi cycle is dropped.
      if (state_reg == RESP && dmem_rv_i) rdata_reg <= dmem_rdata_i;
    end
  end

`ifdef CL_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic       timeout_reg;
  logic       mem_event;

  assign mem_event = (in_req & dmem_yumi_i) | ((state_reg == RESP) & dmem_rv_i);
  assign abort     = (in_req | (state_reg == RESP)) & ~mem_event
                     & (wait_cnt_reg == 8'(MAX_WAIT - 1));
  assign timed_out = timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt_reg <= 8'd0;
        timeout_reg  <= 1'b0;
      end else if (in_req || state_reg == RESP) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
      if (abort) timeout_reg <= 1'b1;
    end
  end
`else
  assign abort     = 1'b0;
  assign timed_out = 1'b0;
`endif

  // Byte lanes are little-endian: lane 0 is bits [7:0].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign mask_steer[gi]         = ~byte_reg | (addr_reg[1:0] == 2'(gi));
    assign wdata_steer[8*gi +: 8] = byte_reg ? data_reg[7:0] : data_reg[8*gi +: 8];
    assign rd_lane[gi]            = rdata_reg[8*gi +: 8];
  end

  assign dmem_v_o     = in_req;
  assign dmem_we_o    = in_req & ~load_reg;
  assign dmem_addr_o  = in_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata_o = (in_req & ~load_reg) ? wdata_steer : '0;
  assign dmem_mask_o  = (in_req & ~load_reg) ? mask_steer : 4'b0000;

  assign wb_v_o        = in_done & load_reg & (rd_reg != 5'd0) & ~timed_out;
  assign wb_rd_o       = wb_v_o ? rd_reg : 5'd0;
  assign wb_data_o     = ~wb_v_o  ? '0 :
                         byte_reg ? {{(DATA_W-8){1'b0}}, rd_lane[addr_reg[1:0]]} : rdata_reg;
  assign err_timeout_o = in_done & timed_out;

endmodule

// File: tb/tb_cl_mem_access_ctrl.sv
// Randomized bench for cl_mem_access_ctrl: a transaction-timeline model sets per-cycle expectations.
module tb_cl_mem_access_ctrl;
`ifdef CL_MEM_TIMEOUT_EN
  localparam int MAXW = 4;
  localparam bit TMO  = 1'b1;
`else
  localparam int MAXW = 64;
  localparam bit TMO  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid_i, is_load_i, is_store_i, is_byte_i;
  logic [31:0] addr_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, dmem_v_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_mask_o;
  logic        dmem_yumi_i, dmem_rv_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_v_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_misalign_o, err_timeout_o;

  always #5 clk = ~clk;

  cl_mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .op_valid_i(op_valid_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .is_byte_i(is_byte_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .stall_o(stall_o), .dmem_v_o(dmem_v_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_mask_o(dmem_mask_o), .dmem_yumi_i(dmem_yumi_i), .dmem_rv_i(dmem_rv_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o)
  );

  // Expected outputs for the current cycle, written by the stimulus model.
  logic        chk_en;
  logic        e_stall, e_v, e_we, e_wb_v, e_mis, e_tmo, e_wr_dc, e_wb_dc;
  logic [31:0] e_addr, e_wdata, e_wb_data;
  logic [3:0]  e_mask;
  logic [4:0]  e_wb_rd;

  int vectors = 0;
  int miscompares = 0;

  // Tallies of observed DUT behaviour, used by the literal spot checks.
  int          stall_cnt, v_cnt, mis_cnt, wbv_cnt, tmo_cnt;
  logic [31:0] last_addr, last_wdata, last_wb_data;
  logic [3:0]  last_mask;
  logic [4:0]  last_wb_rd;
  logic        last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    chk(name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      chk("stall",        32'(stall_o),        32'(e_stall));
      chk("dmem_v",       32'(dmem_v_o),       32'(e_v));
      chk("dmem_we",      32'(dmem_we_o),      32'(e_we));
      chk("dmem_addr",    dmem_addr_o,         e_addr);
      chk("err_misalign", 32'(err_misalign_o), 32'(e_mis));
      chk("err_timeout",  32'(err_timeout_o),  32'(e_tmo));
      chk("wb_v",         32'(wb_v_o),         32'(e_wb_v));
      if (!e_wr_dc) begin
        chk("dmem_mask",  32'(dmem_mask_o),    32'(e_mask));
        chk("dmem_wdata", dmem_wdata_o,        e_wdata);
      end
      if (!e_wb_dc) begin
        chk("wb_rd",      32'(wb_rd_o),        32'(e_wb_rd));
        chk("wb_data",    wb_data_o,           e_wb_data);
      end
      if (stall_o)        stall_cnt++;
      if (err_misalign_o) mis_cnt++;
      if (err_timeout_o)  tmo_cnt++;
      if (dmem_v_o) begin
        v_cnt++;
        last_addr  = dmem_addr_o;
        last_wdata = dmem_wdata_o;
        last_mask  = dmem_mask_o;
        last_we    = dmem_we_o;
      end
      if (wb_v_o) begin
        wbv_cnt++;
        last_wb_rd   = wb_rd_o;
        last_wb_data = wb_data_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_stall = 0; e_v = 0; e_we = 0; e_wb_v = 0; e_mis = 0; e_tmo = 0;
    e_wr_dc = 0; e_wb_dc = 0;
    e_addr = 0; e_wdata = 0; e_wb_data = 0; e_mask = 0; e_wb_rd = 0;
  endtask

  task automatic clr_tally();
    stall_cnt = 0; v_cnt = 0; mis_cnt = 0; wbv_cnt = 0; tmo_cnt = 0;
    last_addr = 0; last_wdata = 0; last_wb_data = 0; last_mask = 0;
    last_wb_rd = 0; last_we = 0;
  endtask

  task automatic idle_cycle();
    op_valid_i = 0;
    is_load_i = 1'($urandom); is_store_i = 1'($urandom); is_byte_i = 1'($urandom);
    addr_i = $urandom; store_data_i = $urandom; rd_addr_i = 5'($urandom);
    dmem_yumi_i = 0; dmem_rv_i = 0; dmem_rdata_i = $urandom;
    exp_idle();
    tick();
  endtask

  // One instruction as a timeline: issue, REQ (yw wait cycles), RESP for loads (rw waits), DONE.
  task automatic do_op(input bit ld, input bit st, input bit byt, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd,
                       input logic [31:0] rdata, input int yw, input int rw);
    bit          aborted = 0;
    bit          req_done = 0;
    bit          resp_done = 0;
    int          k = 0;
    int          sh;
    logic [3:0]  exp_m;
    logic [31:0] exp_wd, exp_wb;
    sh     = 8 * int'(addr[1:0]);
    exp_m  = byt ? (4'b0001 << addr[1:0]) : 4'hF;
    exp_wd = byt ? {4{data[7:0]}} : data;
    exp_wb = byt ? ((rdata >> sh) & 32'hFF) : rdata;

    op_valid_i = 1; is_load_i = ld; is_store_i = st; is_byte_i = byt;
    addr_i = addr; store_data_i = data; rd_addr_i = rd;
    dmem_yumi_i = 0; dmem_rv_i = 0; dmem_rdata_i = $urandom;
    exp_idle();
    if (ld == st) begin
      tick();
      return;
    end
    if (!byt && addr[1:0] != 2'b00) begin
      e_mis = 1;
      tick();
      return;
    end
    e_stall = 1;
    tick();

    for (int i = 0; !req_done && !aborted; i++) begin
      addr_i = $urandom; store_data_i = $urandom; rd_addr_i = 5'($urandom);
      dmem_yumi_i  = (i == yw);
      dmem_rv_i    = ld && (i == yw) && ($urandom_range(0, 1) == 1);
      dmem_rdata_i = $urandom;
      exp_idle();
      e_stall = 1; e_v = 1; e_we = st; e_addr = {addr[31:2], 2'b00};
      e_mask = exp_m; e_wdata = exp_wd; e_wr_dc = ld;
      tick();
      if (i == yw) req_done = 1;
      else if (TMO && k == MAXW - 1) aborted = 1;
      k++;
    end

    if (ld) begin
      for (int j = 0; !resp_done && !aborted; j++) begin
        dmem_yumi_i  = 0;
        dmem_rv_i    = (j == rw);
        dmem_rdata_i = (j == rw) ? rdata : $urandom;
        exp_idle();
        e_stall = 1;
        tick();
        if (j == rw) resp_done = 1;
        else if (TMO && k == MAXW - 1) aborted = 1;
        k++;
      end
    end

    // DONE: the completed op is still presented and must not be taken again.
    addr_i = $urandom; store_data_i = $urandom;
    dmem_yumi_i = 0; dmem_rv_i = 0; dmem_rdata_i = $urandom;
    exp_idle();
    e_tmo  = aborted;
    e_wb_v = ld && !aborted && (rd != 5'd0);
    if (e_wb_v) begin
      e_wb_rd = rd; e_wb_data = exp_wb;
    end else begin
      e_wb_dc = 1;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    chk_en = 0;
    clr_tally();
    exp_idle();
    reset = 1;
    op_valid_i = 0; is_load_i = 0; is_store_i = 0; is_byte_i = 0;
    addr_i = 0; store_data_i = 0; rd_addr_i = 0;
    dmem_yumi_i = 0; dmem_rv_i = 0; dmem_rdata_i = 0;
    tick(); tick();
    reset = 0;
    chk_en = 1;
    idle_cycle();
    idle_cycle();

    clr_tally();
    do_op(1, 0, 0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);
    lit("lw_stall_cycles", stall_cnt, 3);
    lit("lw_wb_count", wbv_cnt, 1);
    lit("lw_wb_rd", 32'(last_wb_rd), 5);
    lit("lw_wb_data", last_wb_data, 32'hDEADBEEF);
    idle_cycle();

    clr_tally();
    do_op(0, 1, 1, 32'h203, 32'h000000A5, 5'd7, 32'h0, 0, 0);
    lit("sb_addr", last_addr, 32'h200);
    lit("sb_mask", 32'(last_mask), 32'h8);
    lit("sb_wdata", last_wdata, 32'hA5A5A5A5);
    lit("sb_we", 32'(last_we), 1);
    lit("sb_stall_cycles", stall_cnt, 2);
    lit("sb_wb_count", wbv_cnt, 0);
    idle_cycle();

    clr_tally();
    do_op(1, 0, 1, 32'h302, 32'h0, 5'd9, 32'h11223344, 1, 2);
    lit("lbu_wb_data", last_wb_data, 32'h00000022);
    clr_tally();
    do_op(1, 0, 1, 32'h302, 32'h0, 5'd0, 32'h11223344, 0, 0);
    lit("lbu_rd0_wb_count", wbv_cnt, 0);
    idle_cycle();

    clr_tally();
    do_op(0, 1, 0, 32'h101, 32'h12345678, 5'd1, 32'h0, 0, 0);
    lit("sw_mis_count", mis_cnt, 1);
    lit("sw_mis_dmem_v", v_cnt, 0);
    lit("sw_mis_stall", stall_cnt, 0);
    idle_cycle();

    clr_tally();
    do_op(0, 1, 0, 32'h400, 32'hCAFEF00D, 5'd2, 32'h0, 5, 0);
    lit("yumi_wait_v_cycles", v_cnt, TMO ? MAXW : 6);
    lit("yumi_wait_stall", stall_cnt, TMO ? MAXW + 1 : 7);
    idle_cycle();

    // Reset while waiting for a load response; the late rv must be ignored.
    clr_tally();
    op_valid_i = 1; is_load_i = 1; is_store_i = 0; is_byte_i = 0;
    addr_i = 32'h500; rd_addr_i = 5'd3;
    exp_idle(); e_stall = 1;
    tick();
    dmem_yumi_i = 1;
    exp_idle(); e_stall = 1; e_v = 1; e_addr = 32'h500; e_wr_dc = 1;
    tick();
    dmem_yumi_i = 0;
    exp_idle(); e_stall = 1;
    tick();
    reset = 1; op_valid_i = 0; chk_en = 0;
    tick();
    reset = 0; chk_en = 1; dmem_rv_i = 1; dmem_rdata_i = 32'h55AA55AA;
    exp_idle();
    tick();
    exp_idle();
    tick();
    dmem_rv_i = 0;
    lit("reset_mid_load_wb", wbv_cnt, 0);
    idle_cycle();

`ifdef CL_MEM_TIMEOUT_EN
    clr_tally();
    do_op(1, 0, 0, 32'h600, 32'h0, 5'd4, 32'h13579BDF, 0, 1000);
    lit("timeout_pulse", tmo_cnt, 1);
    lit("timeout_wb", wbv_cnt, 0);
    idle_cycle();
`endif

    for (int n = 0; n < 300; n++) begin
      int          kind;
      bit          ld, st, byt;
      logic [31:0] a;
      logic [4:0]  rd;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:    begin ld = 1; st = 0; byt = 0; end
        2, 3:    begin ld = 1; st = 0; byt = 1; end
        4, 5:    begin ld = 0; st = 1; byt = 0; end
        6, 7:    begin ld = 0; st = 1; byt = 1; end
        8:       begin ld = 0; st = 0; byt = 1'($urandom); end
        default: begin ld = 1; st = 1; byt = 1'($urandom); end
      endcase
      a = $urandom;
      if (!byt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      do_op(ld, st, byt, a, $urandom, rd, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    idle_cycle();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
